router_sw_00: RTL and testbench
===============================

ROUTER_SW_00 -- requirements
Module: router_sw_00

Interface
REQ-001 Parameters SHALL be: DATASIZE, default 40, flit width; CNTW, default 16, statistics counter width.
REQ-002 Ports SHALL be as follows, clock and reset first:
 fifo_clk  in  1  single clock; all state on rising edge.
 rst  in  1  synchronous, active-high reset.
 {E,S,L}_data_in  in  DATASIZE  head flit of each input FIFO.
 {E,S,L}_valid_in  in  1  input FIFO non-empty.
 fifo_ready_{E,S,L}  out  1  pop strobe to each input FIFO.
 {E,S,L}_data_out  out  DATASIZE  registered output flit.
 {E,S,L}_valid_out  out  1  output register holds a flit.
 {E,S,L}_full_in  in  1  downstream FIFO full; blocks transfer.
 drop_pulse  out  1  one-cycle pulse on U-turn discard.
 {E,S,L}_fwd_cnt  out  CNTW  flits forwarded per output (see REQ-017).
REQ-003 One clock SHALL be used; reset SHALL be synchronous and active-high.

Function
REQ-004 Routing SHALL be XY on flit header: dx = data[DATASIZE-1:DATASIZE-2], dy = data[DATASIZE-3:DATASIZE-4]; node is (0,0).
REQ-005 Route SHALL be: dx != 0 -> E; else dy != 0 -> S; else L.
REQ-006 A flit whose route equals its arrival port (E->E, S->S) SHALL be a U-turn: popped without arbitration, discarded, drop_pulse = 1 that cycle.
REQ-007 Each output SHALL have one flit register; the register is "free" when valid_out = 0 or full_in = 0 in the same cycle.
REQ-008 Each output SHALL run a round-robin arbiter over non-U-turn requesters in order E, S, L; at most one grant per output per cycle.
REQ-009 After a grant, that output's priority pointer SHALL move to the port after the winner (wrapping L -> E); without a grant it SHALL hold.
REQ-010 An input SHALL be granted only if its target output is free; fifo_ready_X SHALL be combinational, asserted in the grant cycle only.
REQ-011 On a grant in cycle N, the flit SHALL appear on X_data_out with X_valid_out = 1 from cycle N+1 (latency 1).
REQ-012 An output flit SHALL be transferred downstream at every edge with valid_out = 1 and full_in = 0; valid_out SHALL then clear unless reloaded in the same cycle.
REQ-013 Same-cycle drain and reload SHALL sustain 1 flit/cycle per output.
REQ-014 While full_in = 1, data_out and valid_out SHALL hold and no grant SHALL be issued to that output.
REQ-015 Losing inputs SHALL see fifo_ready = 0 and retry next cycle; no flit SHALL be lost or duplicated.

Reset
REQ-016 With rst = 1 at an edge, all valid_out, fifo_ready (combinational, forced 0 during rst), drop_pulse and counters SHALL be 0, data_out SHALL be 0, pointers SHALL be at E; in-flight output flits SHALL be discarded.

Configuration
REQ-017 Macro ROUTER_SW_STAT_EN: when defined, each {X}_fwd_cnt SHALL increment on each downstream transfer from output X, saturating at 2^CNTW-1; when undefined, the counters SHALL not be built and the ports SHALL be tied to 0.

Verification
REQ-018 Bench SHALL cover these scenarios:
 - L_valid_in with header dx=1 -> fifo_ready_L=1 in cycle N, E_valid_out=1 with identical data in N+1.
 - E, S, L all valid targeting L (dx=0, dy=0 from S is not U-turn since route L): grants over 3 cycles in order E, S, L after reset; 4th round starts at E.
 - L_full_in=1 for 5 cycles with a flit held -> L_data_out stable, no fifo_ready to L-bound inputs; release -> transfer next edge.
 - S_data_in dx=0, dy=1 (S->S U-turn) -> fifo_ready_S=1, drop_pulse=1 one cycle, no output valid.
 - Continuous L->E stream, E_full_in=0 -> one flit/cycle, E_fwd_cnt = 10 after 10 transfers (STAT_EN defined); 0 when undefined.
 - rst=1 while E_valid_out=1 -> next cycle E_valid_out=0, counters 0, pointers at E.

Source files
------------

// File: rtl/router_sw_00.sv
// router_sw_00 -- three-port (E, S, L) XY switch for node (0,0).
// Each output owns one flit register fed by a round-robin arbiter over the
// inputs routed to it. A flit whose route points back at its arrival port
// (E->E, S->S) is popped and discarded with a drop_pulse.
// Optional feature: define ROUTER_SW_STAT_EN to build saturating per-output
// forward counters; without it the *_fwd_cnt ports are tied to zero.
module router_sw_00 #(
   parameter int DATASIZE = 40,
   parameter int CNTW     = 16
) (
   input  logic                fifo_clk,
   input  logic                rst,
   input  logic [DATASIZE-1:0] E_data_in,
   input  logic [DATASIZE-1:0] S_data_in,
   input  logic [DATASIZE-1:0] L_data_in,
   input  logic                E_valid_in,
   input  logic                S_valid_in,
   input  logic                L_valid_in,
   output logic                fifo_ready_E,
   output logic                fifo_ready_S,
   output logic                fifo_ready_L,
   output logic [DATASIZE-1:0] E_data_out,
   output logic [DATASIZE-1:0] S_data_out,
   output logic [DATASIZE-1:0] L_data_out,
   output logic                E_valid_out,
   output logic                S_valid_out,
   output logic                L_valid_out,
   input  logic                E_full_in,
   input  logic                S_full_in,
   input  logic                L_full_in,
   output logic                drop_pulse,
   output logic [CNTW-1:0]     E_fwd_cnt,
   output logic [CNTW-1:0]     S_fwd_cnt,
   output logic [CNTW-1:0]     L_fwd_cnt
);

   // Port indices; also the encoding of a route and of a priority pointer.
   localparam logic [1:0] P_E = 2'd0;
   localparam logic [1:0] P_S = 2'd1;
   localparam logic [1:0] P_L = 2'd2;

   logic [DATASIZE-1:0]   din_s [3];
   logic [2:0]            vin_s;
   logic [2:0]            full_s;
   logic [1:0]            route_s [3];
   logic [2:0]            uturn_s;
   logic [8:0]            grant_all_s;   // [3*o + i] : output o grants input i
   logic [2:0]            vout_all_s;
   logic [3*DATASIZE-1:0] dout_all_s;
   logic [3*CNTW-1:0]     cnt_all_s;

   assign din_s[0] = E_data_in;
   assign din_s[1] = S_data_in;
   assign din_s[2] = L_data_in;
   assign vin_s    = {L_valid_in, S_valid_in, E_valid_in};
   assign full_s   = {L_full_in, S_full_in, E_full_in};

   // XY route: any x offset goes East first, then any y offset South, else Local.
   function automatic logic [1:0] route_of(input logic [DATASIZE-1:0] d);
      logic [1:0] r;
      if (d[DATASIZE-1 -: 2] != 2'b00) begin
         r = P_E;
      end else if (d[DATASIZE-3 -: 2] != 2'b00) begin
         r = P_S;
      end else begin
         r = P_L;
      end
      return r;
   endfunction

   // Round-robin pick starting at ptr, scanning E -> S -> L with wrap.
   function automatic logic [2:0] rr_pick(input logic [2:0] req, input logic [1:0] ptr);
      logic [2:0] g;
      g = 3'b000;
      case (ptr)
         P_S: begin
            if (req[1])      g = 3'b010;
            else if (req[2]) g = 3'b100;
            else if (req[0]) g = 3'b001;
            else             g = 3'b000;
         end
         P_L: begin
            if (req[2])      g = 3'b100;
            else if (req[0]) g = 3'b001;
            else if (req[1]) g = 3'b010;
            else             g = 3'b000;
         end
         default: begin
            if (req[0])      g = 3'b001;
            else if (req[1]) g = 3'b010;
            else if (req[2]) g = 3'b100;
            else             g = 3'b000;
         end
      endcase
      return g;
   endfunction

   // Decode each head flit's route and flag U-turns (only E and S can U-turn).
   always_comb begin
      route_s[0] = route_of(din_s[0]);
      route_s[1] = route_of(din_s[1]);
      route_s[2] = route_of(din_s[2]);
      uturn_s[0] = vin_s[0] && (route_s[0] == P_E);
      uturn_s[1] = vin_s[1] && (route_s[1] == P_S);
      uturn_s[2] = 1'b0;
   end

   // Pop strobes: a granted input or a U-turn head is consumed this cycle.
   always_comb begin
      if (rst) begin
         fifo_ready_E = 1'b0;
         fifo_ready_S = 1'b0;
         fifo_ready_L = 1'b0;
         drop_pulse   = 1'b0;
      end else begin
         fifo_ready_E = uturn_s[0] || grant_all_s[0] || grant_all_s[3] || grant_all_s[6];
         fifo_ready_S = uturn_s[1] || grant_all_s[1] || grant_all_s[4] || grant_all_s[7];
         fifo_ready_L = uturn_s[2] || grant_all_s[2] || grant_all_s[5] || grant_all_s[8];
         drop_pulse   = |uturn_s;
      end
   end

   for (genvar o = 0; o < 3; o++) begin : g_out
      localparam logic [1:0] OID = 2'(o);

      logic [2:0]          req_s;
      logic                free_s;
      logic [2:0]          grant_s;
      logic [DATASIZE-1:0] mux_s;
      logic [1:0]          nxt_s;
      logic                vout_r;
      logic [DATASIZE-1:0] dout_r;
      logic [1:0]          ptr_r;

      // Collect requesters for this output and arbitrate when the register can take a flit.
      always_comb begin
         req_s[0] = vin_s[0] && !uturn_s[0] && (route_s[0] == OID);
         req_s[1] = vin_s[1] && !uturn_s[1] && (route_s[1] == OID);
         req_s[2] = vin_s[2] && !uturn_s[2] && (route_s[2] == OID);
         free_s   = !vout_r || !full_s[o];
         if (free_s && !rst) begin
            grant_s = rr_pick(req_s, ptr_r);
         end else begin
            grant_s = 3'b000;
         end
         case (grant_s)
            3'b001: begin
               mux_s = din_s[0];
               nxt_s = P_S;
            end
            3'b010: begin
               mux_s = din_s[1];
               nxt_s = P_L;
            end
            3'b100: begin
               mux_s = din_s[2];
               nxt_s = P_E;
            end
            default: begin
               mux_s = dout_r;
               nxt_s = ptr_r;
            end
         endcase
      end

      // Output flit register: reload on grant, otherwise clear once drained downstream.
      always_ff @(posedge fifo_clk) begin
         if (rst) begin
            vout_r <= 1'b0;
            dout_r <= {DATASIZE{1'b0}};
            ptr_r  <= P_E;
         end else if (grant_s != 3'b000) begin
            vout_r <= 1'b1;
            dout_r <= mux_s;
            ptr_r  <= nxt_s;
         end else if (vout_r && !full_s[o]) begin
            vout_r <= 1'b0;
         end
      end

      assign grant_all_s[3*o +: 3]               = grant_s;
      assign vout_all_s[o]                       = vout_r;
      assign dout_all_s[o*DATASIZE +: DATASIZE]  = dout_r;

`ifdef ROUTER_SW_STAT_EN
      logic [CNTW-1:0] cnt_r;

      // Count downstream transfers, saturating at all-ones.
      always_ff @(posedge fifo_clk) begin
         if (rst) begin
            cnt_r <= {CNTW{1'b0}};
         end else if (vout_r && !full_s[o] && (cnt_r != {CNTW{1'b1}})) begin
            cnt_r <= cnt_r + {{(CNTW-1){1'b0}}, 1'b1};
         end else begin
            cnt_r <= cnt_r;
         end
      end

      assign cnt_all_s[o*CNTW +: CNTW] = cnt_r;
`endif
   end

`ifndef ROUTER_SW_STAT_EN
   assign cnt_all_s = {(3*CNTW){1'b0}};
`endif

   assign E_valid_out = vout_all_s[0];
   assign S_valid_out = vout_all_s[1];
   assign L_valid_out = vout_all_s[2];
   assign E_data_out  = dout_all_s[0*DATASIZE +: DATASIZE];
   assign S_data_out  = dout_all_s[1*DATASIZE +: DATASIZE];
   assign L_data_out  = dout_all_s[2*DATASIZE +: DATASIZE];
   assign E_fwd_cnt   = cnt_all_s[0*CNTW +: CNTW];
   assign S_fwd_cnt   = cnt_all_s[1*CNTW +: CNTW];
   assign L_fwd_cnt   = cnt_all_s[2*CNTW +: CNTW];

endmodule

// File: tb/tb_router_sw_00.sv
// Testbench for router_sw_00: directed scenarios followed by random traffic,
// all checked against a queue-based behavioural model of the switch.
module tb_router_sw_00;
   localparam int DS = 40;
   localparam int CW = 16;

   logic          fifo_clk = 1'b0;
   logic          rst;
   logic [DS-1:0] E_data_in, S_data_in, L_data_in;
   logic          E_valid_in, S_valid_in, L_valid_in;
   logic          fifo_ready_E, fifo_ready_S, fifo_ready_L;
   logic [DS-1:0] E_data_out, S_data_out, L_data_out;
   logic          E_valid_out, S_valid_out, L_valid_out;
   logic          E_full_in, S_full_in, L_full_in;
   logic          drop_pulse;
   logic [CW-1:0] E_fwd_cnt, S_fwd_cnt, L_fwd_cnt;

   router_sw_00 #(.DATASIZE(DS), .CNTW(CW)) dut (
      .fifo_clk(fifo_clk), .rst(rst),
      .E_data_in(E_data_in), .S_data_in(S_data_in), .L_data_in(L_data_in),
      .E_valid_in(E_valid_in), .S_valid_in(S_valid_in), .L_valid_in(L_valid_in),
      .fifo_ready_E(fifo_ready_E), .fifo_ready_S(fifo_ready_S), .fifo_ready_L(fifo_ready_L),
      .E_data_out(E_data_out), .S_data_out(S_data_out), .L_data_out(L_data_out),
      .E_valid_out(E_valid_out), .S_valid_out(S_valid_out), .L_valid_out(L_valid_out),
      .E_full_in(E_full_in), .S_full_in(S_full_in), .L_full_in(L_full_in),
      .drop_pulse(drop_pulse),
      .E_fwd_cnt(E_fwd_cnt), .S_fwd_cnt(S_fwd_cnt), .L_fwd_cnt(L_fwd_cnt)
   );

   always #5 fifo_clk = ~fifo_clk;

   int total = 0;
   int bad   = 0;

   // Reference model: input FIFOs as queues, outputs as slot + pointer + count.
   logic [DS-1:0] q [3][$];
   bit            full [3];
   int            ptr [3];
   bit            mv [3];
   logic [DS-1:0] md [3];
   int            mc [3];
   int            win [3];
   bit            mready [3];
   bit            mdrop;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int route(input logic [DS-1:0] d);
      if (d[DS-1:DS-2] != 2'b00) return 0;
      if (d[DS-3:DS-4] != 2'b00) return 1;
      return 2;
   endfunction

   function automatic logic [DS-1:0] mk(input int dx, input int dy);
      logic [63:0] r;
      logic [DS-1:0] f;
      r = {$urandom(), $urandom()};
      f = {2'(dx), 2'(dy), r[DS-5:0]};
      return f;
   endfunction

   function automatic int expcnt(input int o);
`ifdef ROUTER_SW_STAT_EN
      return mc[o];
`else
      return 0 + (o - o);
`endif
   endfunction

   function automatic logic [DS-1:0] head(input int i);
      if (q[i].size() > 0) return q[i][0];
      return '0;
   endfunction

   // One clock: drive inputs, predict, check at negedge, advance model at posedge.
   task automatic tick(input string tag);
      int c;
      int r;
      logic [DS-1:0] ld [3];
      E_valid_in = (q[0].size() > 0); E_data_in = head(0);
      S_valid_in = (q[1].size() > 0); S_data_in = head(1);
      L_valid_in = (q[2].size() > 0); L_data_in = head(2);
      E_full_in = full[0]; S_full_in = full[1]; L_full_in = full[2];
      mdrop = 0;
      for (int i = 0; i < 3; i++) begin mready[i] = 0; win[i] = -1; end
      if (!rst) begin
         for (int i = 0; i < 2; i++)
            if (q[i].size() > 0 && route(q[i][0]) == i) begin mready[i] = 1; mdrop = 1; end
         for (int o = 0; o < 3; o++) begin
            if (!mv[o] || !full[o]) begin
               for (int k = 0; k < 3; k++) begin
                  c = (ptr[o] + k) % 3;
                  if (win[o] < 0 && q[c].size() > 0) begin
                     r = route(q[c][0]);
                     if (r == o && !(c < 2 && r == c)) win[o] = c;
                  end
               end
            end
            if (win[o] >= 0) mready[win[o]] = 1;
         end
      end
      @(negedge fifo_clk);
      chk({tag, ":ready_E"}, 64'(fifo_ready_E), 64'(mready[0]));
      chk({tag, ":ready_S"}, 64'(fifo_ready_S), 64'(mready[1]));
      chk({tag, ":ready_L"}, 64'(fifo_ready_L), 64'(mready[2]));
      chk({tag, ":drop"},    64'(drop_pulse),   64'(mdrop));
      chk({tag, ":vout_E"},  64'(E_valid_out),  64'(mv[0]));
      chk({tag, ":vout_S"},  64'(S_valid_out),  64'(mv[1]));
      chk({tag, ":vout_L"},  64'(L_valid_out),  64'(mv[2]));
      if (mv[0]) chk({tag, ":data_E"}, 64'(E_data_out), 64'(md[0]));
      if (mv[1]) chk({tag, ":data_S"}, 64'(S_data_out), 64'(md[1]));
      if (mv[2]) chk({tag, ":data_L"}, 64'(L_data_out), 64'(md[2]));
      chk({tag, ":cnt_E"}, 64'(E_fwd_cnt), 64'(expcnt(0)));
      chk({tag, ":cnt_S"}, 64'(S_fwd_cnt), 64'(expcnt(1)));
      chk({tag, ":cnt_L"}, 64'(L_fwd_cnt), 64'(expcnt(2)));
      @(posedge fifo_clk);
      if (rst) begin
         for (int o = 0; o < 3; o++) begin mv[o] = 0; md[o] = '0; ptr[o] = 0; mc[o] = 0; end
      end else begin
         for (int i = 0; i < 3; i++) ld[i] = head(i);
         for (int o = 0; o < 3; o++) begin
            if (mv[o] && !full[o] && mc[o] < (1 << CW) - 1) mc[o]++;
            if (win[o] >= 0) begin
               md[o] = ld[win[o]]; mv[o] = 1; ptr[o] = (win[o] + 1) % 3;
            end else if (mv[o] && !full[o]) begin
               mv[o] = 0;
            end
         end
         for (int i = 0; i < 3; i++) if (mready[i]) void'(q[i].pop_front());
      end
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick("reset");
      rst = 1'b0;
   endtask

   initial begin
      logic [DS-1:0] f;
      int n;
      rst = 1'b1;
      for (int o = 0; o < 3; o++) begin full[o] = 0; mv[o] = 0; md[o] = '0; ptr[o] = 0; mc[o] = 0; end
      E_data_in = '0; S_data_in = '0; L_data_in = '0;
      E_valid_in = 0; S_valid_in = 0; L_valid_in = 0;
      E_full_in = 0; S_full_in = 0; L_full_in = 0;
      tick("reset");
      tick("reset");
      rst = 1'b0;
      chk("reset:vout_E", 64'(E_valid_out), 64'(0));
      chk("reset:data_L", 64'(L_data_out), 64'(0));
      tick("idle");

      // Local flit with dx=1 goes East with one cycle latency.
      f = mk(1, 0);
      q[2].push_back(f);
      tick("l2e_grant");
      tick("l2e_out");
      chk("l2e:data_E", 64'(E_data_out), 64'(f));

      // Three inputs all bound for L: E, S, L in turn, then E again.
      do_reset();
      for (int r = 0; r < 2; r++) for (int i = 0; i < 3; i++) q[i].push_back(mk(0, 0));
      for (int k = 0; k < 8; k++) tick("rr_to_L");

      // L output held full for five cycles with a waiting L-bound flit.
      q[2].push_back(mk(0, 0));
      tick("full_load");
      full[2] = 1;
      f = L_data_out;
      q[0].push_back(mk(0, 0));
      for (int k = 0; k < 5; k++) tick("full_hold");
      full[2] = 0;
      tick("full_release");
      tick("full_after");
      tick("full_after");

      // S input heading South is a U-turn and is dropped.
      q[1].push_back(mk(0, 1));
      tick("uturn_S");
      tick("uturn_after");

      // Continuous L->E stream of ten flits.
      do_reset();
      for (int k = 0; k < 10; k++) q[2].push_back(mk(2, 3));
      for (int k = 0; k < 12; k++) tick("stream");
`ifdef ROUTER_SW_STAT_EN
      chk("stream:cnt10", 64'(E_fwd_cnt), 64'(10));
`else
      chk("stream:cnt0", 64'(E_fwd_cnt), 64'(0));
`endif

      // Reset while an East flit is held.
      q[2].push_back(mk(3, 0));
      full[0] = 1;
      tick("pre_rst");
      tick("pre_rst");
      chk("pre_rst:vout_E", 64'(E_valid_out), 64'(1));
      rst = 1'b1;
      tick("mid_rst");
      rst = 1'b0;
      full[0] = 0;
      chk("post_rst:vout_E", 64'(E_valid_out), 64'(0));
      chk("post_rst:cnt_E", 64'(E_fwd_cnt), 64'(0));
      tick("post_rst");

      // Random traffic with random back-pressure.
      for (int k = 0; k < 400; k++) begin
         for (int i = 0; i < 3; i++)
            if ($urandom_range(0, 1) == 1 && q[i].size() < 4)
               q[i].push_back(mk(int'($urandom_range(0, 3)), int'($urandom_range(0, 3))));
         for (int o = 0; o < 3; o++) full[o] = ($urandom_range(0, 3) == 0);
         tick("rand");
      end
      for (int o = 0; o < 3; o++) full[o] = 0;
      n = 0;
      while ((q[0].size() + q[1].size() + q[2].size()) > 0 && n < 100) begin
         tick("drain");
         n++;
      end
      chk("drain:empty", 64'(q[0].size() + q[1].size() + q[2].size()), 64'(0));
      tick("final");
      tick("final");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
